// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller with a single-line memory port.
// Rev 1.0
`default_nettype none

module dcache_ctrl #(
  parameter int NLINES      = 4,
  parameter int MEM_LAT_MAX = 255
) (
  input  logic         clk_i,
  input  logic         rsn_i,
  input  logic         tl_cache_enable_i,
  input  logic         tl_store_i,
  input  logic [1:0]   tl_size_i,
  input  logic [31:0]  tl_cache_addr_i,
  input  logic [31:0]  tl_store_data_i,
  output logic [31:0]  dc_read_data_o,
  output logic         dc_hit_o,
  output logic         dc_stall_o,
  output logic         dc_err_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic         mem_ack_i,
  input  logic [127:0] mem_rdata_i
);

  localparam int IDXW = $clog2(NLINES);
  localparam int TAGW = 28 - IDXW;
  localparam int CNTW = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WBACK  = 2'd1,
    S_REFILL = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic [NLINES-1:0] r_valid;
  logic [NLINES-1:0] r_dirty;
  logic [TAGW-1:0]   r_tag  [NLINES];
  logic [127:0]      r_data [NLINES];
  logic [27:0]       r_miss_line;
  logic [CNTW-1:0]   r_lat_cnt;
  logic              r_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [127:0]      r_mem_wdata;

  logic [IDXW-1:0] w_idx;
  logic [TAGW-1:0] w_tag;
  logic [1:0]      w_word;
  logic [IDXW-1:0] w_miss_idx;
  logic [TAGW-1:0] w_miss_tag;
  logic            w_lookup;
  logic            w_hit;
  logic            w_miss;
  logic            w_ack;
  logic            w_timeout;
  logic [127:0]    w_line;
  logic [3:0]      w_be4;
  logic [15:0]     w_be16;
  logic [31:0]     w_wdata32;
  logic [127:0]    w_wdata;
  logic [127:0]    w_store_line;

  assign w_idx      = tl_cache_addr_i[IDXW+3:4];
  assign w_tag      = tl_cache_addr_i[31:IDXW+4];
  assign w_word     = tl_cache_addr_i[3:2];
  assign w_miss_idx = r_miss_line[IDXW-1:0];
  assign w_miss_tag = r_miss_line[27:IDXW];

  assign w_lookup  = (r_state == S_IDLE) && tl_cache_enable_i;
  assign w_hit     = w_lookup && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss    = w_lookup && !w_hit;
  assign w_ack     = r_mem_req && mem_ack_i;
  assign w_timeout = r_mem_req && !mem_ack_i && (r_lat_cnt == CNTW'(MEM_LAT_MAX - 1));
  assign w_line    = r_data[w_idx];

  // Size 2'b11 falls into the word case along with 2'b10.
  always_comb begin
    w_be4     = 4'b1111;
    w_wdata32 = tl_store_data_i;
    case (tl_size_i)
      2'b00: begin
        w_be4     = 4'b0001 << tl_cache_addr_i[1:0];
        w_wdata32 = {4{tl_store_data_i[7:0]}};
      end
      2'b01: begin
        w_be4     = tl_cache_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata32 = {2{tl_store_data_i[15:0]}};
      end
      default: begin
        w_be4     = 4'b1111;
        w_wdata32 = tl_store_data_i;
      end
    endcase
  end

  assign w_be16  = {12'b0, w_be4} << {w_word, 2'b00};
  assign w_wdata = {4{w_wdata32}};

  always_comb begin
    w_store_line = w_line;
    for (int b = 0; b < 16; b++) begin
      if (w_be16[b]) w_store_line[b*8 +: 8] = w_wdata[b*8 +: 8];
    end
  end

  assign dc_hit_o       = w_hit;
  assign dc_read_data_o = w_hit ? w_line[{w_word, 5'b0} +: 32] : 32'd0;
  assign dc_stall_o     = (r_state == S_IDLE) ? w_miss : 1'b1;
  assign dc_err_o       = r_err;
  assign mem_req_o      = r_mem_req;
  assign mem_we_o       = r_mem_we;
  assign mem_addr_o     = r_mem_addr;
  assign mem_wdata_o    = r_mem_wdata;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_miss_line <= '0;
      r_lat_cnt   <= '0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (!r_mem_req || mem_ack_i || w_timeout) r_lat_cnt <= '0;
      else                                      r_lat_cnt <= r_lat_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_hit && tl_store_i) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (w_miss) begin
            r_miss_line <= tl_cache_addr_i[31:4];
            r_mem_req   <= 1'b1;
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state     <= S_WBACK;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx], w_idx, 4'b0};
              r_mem_wdata <= w_line;
            end else begin
              r_state    <= S_REFILL;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx, 4'b0};
            end
          end
        end
        S_WBACK, S_REFILL: begin
          if (w_timeout) begin
            r_err       <= 1'b1;
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end else if (w_ack && r_state == S_WBACK) begin
            r_dirty[w_miss_idx] <= 1'b0;
            r_state             <= S_REFILL;
            r_mem_we            <= 1'b0;
            r_mem_addr          <= {w_miss_tag, w_miss_idx, 4'b0};
            r_mem_wdata         <= '0;
          end else if (w_ack) begin
            r_valid[w_miss_idx] <= 1'b1;
            r_dirty[w_miss_idx] <= 1'b0;
            r_state             <= S_DONE;
            r_mem_req           <= 1'b0;
            r_mem_addr          <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (w_hit && tl_store_i) begin
      r_data[w_idx] <= w_store_line;
    end else if (r_state == S_REFILL && w_ack) begin
      r_data[w_miss_idx] <= mem_rdata_i;
      r_tag[w_miss_idx]  <= w_miss_tag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scoreboard bench for dcache_ctrl with a latency-programmable memory responder.
// Rev 1.0
`default_nettype none

module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rsn_i;
  logic         tl_cache_enable_i;
  logic         tl_store_i;
  logic [1:0]   tl_size_i;
  logic [31:0]  tl_cache_addr_i;
  logic [31:0]  tl_store_data_i;
  logic [31:0]  dc_read_data_o;
  logic         dc_hit_o;
  logic         dc_stall_o;
  logic         dc_err_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ack_i;
  logic [127:0] mem_rdata_i;

  dcache_ctrl #(.NLINES(4), .MEM_LAT_MAX(255)) dut (
    .clk_i             (clk_i),
    .rsn_i             (rsn_i),
    .tl_cache_enable_i (tl_cache_enable_i),
    .tl_store_i        (tl_store_i),
    .tl_size_i         (tl_size_i),
    .tl_cache_addr_i   (tl_cache_addr_i),
    .tl_store_data_i   (tl_store_data_i),
    .dc_read_data_o    (dc_read_data_o),
    .dc_hit_o          (dc_hit_o),
    .dc_stall_o        (dc_stall_o),
    .dc_err_o          (dc_err_o),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_ack_i         (mem_ack_i),
    .mem_rdata_i       (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  int           checks   = 0;
  int           failures = 0;
  mem_exp_t     exp_mem_q[$];
  logic [31:0]  rd_q[$];
  logic [127:0] mem [logic [31:0]];
  int           lat_cfg   = 3;
  bit           mem_mute  = 1'b0;
  logic         stray_ack = 1'b0;

  localparam logic [127:0] L40 = {32'h4444_0003, 32'h4444_0002, 32'h1122_3344, 32'hCAFE_0040};
  localparam logic [127:0] LC0 = {32'hC0C0_0003, 32'hC0C0_0002, 32'h0C0C_0C04, 32'hC0C0_0000};
  localparam logic [127:0] WB0 = {32'h0102_0304, 32'h5566_0002, 32'hDEAD_BEEF, 32'hCAFE_0040};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a + 32'h5A00_000C, a + 32'h5A00_0008, a + 32'h5A00_0004, a + 32'h5A00_0000};
  endfunction

  task automatic expect_mem(input logic we, input logic [31:0] a, input logic [127:0] wd);
    mem_exp_t e;
    e.we = we; e.addr = a; e.wdata = wd;
    exp_mem_q.push_back(e);
  endtask

  // Memory responder: compares each new request with the scoreboard, acks after lat_cfg cycles.
  initial begin
    int          req_cycles;
    logic [31:0] cur_addr;
    mem_exp_t    e;
    req_cycles  = 0;
    cur_addr    = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = stray_ack;
      if (mem_req_o) begin
        if (req_cycles == 0) begin
          check("mem_req_expected", exp_mem_q.size() != 0, 1'b1);
          if (exp_mem_q.size() != 0) begin
            e = exp_mem_q.pop_front();
            check("mem_we", mem_we_o, e.we);
            check("mem_addr", mem_addr_o, e.addr);
            if (e.we) check("mem_wdata", mem_wdata_o, e.wdata);
          end
          cur_addr = mem_addr_o;
        end
        req_cycles++;
        if (!mem_mute && req_cycles == lat_cfg) begin
          check("mem_addr_stable", mem_addr_o, cur_addr);
          mem_ack_i   = 1'b1;
          mem_rdata_i = line_of(mem_addr_o);
          if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
          req_cycles = 0;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  task automatic access(input logic st, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int exp_stall,
                        input string tag);
    int n;
    tl_cache_enable_i = 1'b1;
    tl_store_i        = st;
    tl_size_i         = sz;
    tl_cache_addr_i   = a;
    tl_store_data_i   = d;
    rd_q.push_back(exp_rd);
    n = 0;
    #3;
    while (!dc_hit_o && n < 400) begin
      n++;
      @(posedge clk_i); #4;
    end
    check({tag, "_hit"}, dc_hit_o, 1'b1);
    check({tag, "_rdata"}, dc_read_data_o, rd_q.pop_front());
    check({tag, "_stall_cycles"}, n, exp_stall);
    check({tag, "_stall_at_hit"}, dc_stall_o, 1'b0);
    @(posedge clk_i); #1;
    tl_cache_enable_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    rsn_i = 1'b1;
    tl_cache_enable_i = 1'b0;
    tl_store_i = 1'b0;
    tl_size_i = 2'b10;
    tl_cache_addr_i = '0;
    tl_store_data_i = '0;
    mem[32'h40] = L40;
    mem[32'hC0] = LC0;

    #2 rsn_i = 1'b0;
    #1;
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_mem_we", mem_we_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 128'h0);
    check("rst_err", dc_err_o, 1'b0);
    check("rst_stall", dc_stall_o, 1'b0);
    check("rst_hit", dc_hit_o, 1'b0);
    check("rst_rdata", dc_read_data_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #2 rsn_i = 1'b1;
    @(posedge clk_i); #1;
    tl_cache_addr_i = 32'h40;
    #3;
    check("idle_disabled_stall", dc_stall_o, 1'b0);
    check("idle_disabled_req", mem_req_o, 1'b0);
    @(posedge clk_i); #1;

    // Cold fill, sub-word stores, then a dirty eviction and a re-fill of the written-back line.
    expect_mem(1'b0, 32'h40, '0);
    access(1'b0, 2'b10, 32'h40, 32'h0, 32'hCAFE_0040, 5, "cold_load");
    access(1'b0, 2'b10, 32'h44, 32'h0, 32'h1122_3344, 0, "hit_load");
    access(1'b1, 2'b00, 32'h47, 32'hFFFF_FFAB, 32'h1122_3344, 0, "st_byte");
    access(1'b0, 2'b10, 32'h44, 32'h0, 32'hAB22_3344, 0, "ld_byte");
    access(1'b1, 2'b01, 32'h4A, 32'h1234_5566, 32'h4444_0002, 0, "st_half");
    access(1'b0, 2'b10, 32'h48, 32'h0, 32'h5566_0002, 0, "ld_half");
    access(1'b1, 2'b11, 32'h4D, 32'h0102_0304, 32'h4444_0003, 0, "st_size3");
    access(1'b0, 2'b10, 32'h4C, 32'h0, 32'h0102_0304, 0, "ld_size3");
    access(1'b1, 2'b10, 32'h44, 32'hDEAD_BEEF, 32'hAB22_3344, 0, "st_word");
    access(1'b0, 2'b10, 32'h44, 32'h0, 32'hDEAD_BEEF, 0, "ld_word");
    expect_mem(1'b1, 32'h40, WB0);
    expect_mem(1'b0, 32'hC0, '0);
    access(1'b0, 2'b10, 32'hC4, 32'h0, 32'h0C0C_0C04, 8, "evict_load");
    expect_mem(1'b0, 32'h40, '0);
    access(1'b0, 2'b10, 32'h44, 32'h0, 32'hDEAD_BEEF, 5, "wb_roundtrip");
    expect_mem(1'b0, 32'h50, '0);
    access(1'b0, 2'b10, 32'h54, 32'h0, 32'h5A00_0054, 5, "index1_load");

    // Reset in the middle of a slow refill; a stray ack afterwards must be ignored.
    lat_cfg = 8;
    expect_mem(1'b0, 32'h60, '0);
    tl_cache_enable_i = 1'b1;
    tl_store_i = 1'b0;
    tl_size_i = 2'b10;
    tl_cache_addr_i = 32'h60;
    repeat (3) @(posedge clk_i);
    #2 rsn_i = 1'b0;
    stray_ack = 1'b1;
    #1;
    check("midrst_req", mem_req_o, 1'b0);
    check("midrst_err", dc_err_o, 1'b0);
    @(posedge clk_i);
    #2 rsn_i = 1'b1;
    tl_cache_enable_i = 1'b0;
    @(posedge clk_i); #4;
    check("stray_ack_req", mem_req_o, 1'b0);
    check("stray_ack_stall", dc_stall_o, 1'b0);
    @(posedge clk_i); #1;
    stray_ack = 1'b0;
    lat_cfg = 3;
    expect_mem(1'b0, 32'h60, '0);
    access(1'b0, 2'b10, 32'h60, 32'h0, 32'h5A00_0060, 5, "post_rst_load");

    // Memory never answers: timeout after MEM_LAT_MAX request cycles.
    mem_mute = 1'b1;
    expect_mem(1'b0, 32'h80, '0);
    tl_cache_enable_i = 1'b1;
    tl_cache_addr_i = 32'h80;
    #3;
    k = 0;
    n = 0;
    while (k < 255 && n < 400) begin
      if (mem_req_o) k++;
      n++;
      if (k < 255) begin
        @(posedge clk_i); #4;
      end
    end
    check("timeout_req_cycles", k, 255);
    check("err_before_limit", dc_err_o, 1'b0);
    @(posedge clk_i); #1;
    tl_cache_enable_i = 1'b0;
    mem_mute = 1'b0;
    #3;
    check("timeout_err", dc_err_o, 1'b1);
    check("timeout_req", mem_req_o, 1'b0);
    check("timeout_idle_stall", dc_stall_o, 1'b0);
    @(posedge clk_i); #1;
    expect_mem(1'b0, 32'h80, '0);
    access(1'b0, 2'b10, 32'h80, 32'h0, 32'h5A00_0080, 5, "after_timeout");
    check("err_sticky", dc_err_o, 1'b1);
    check("mem_scoreboard_drained", exp_mem_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
